// File: rtl/data_sram_resp.sv
// data_sram_resp
// Data-memory responder on the far side of the data_sram_* request bus.
// It holds a byte-lane RAM of 2^ADDR_W 32-bit words and posts byte, half and
// word stores. Stores whose write enables disagree with addr[1:0] are dropped
// and flagged. Loads return a full word after READ_LAT cycles (1..4).
//
// Ports
//   clk               rising-edge clock
//   rst               asynchronous active-high reset
//   data_sram_en      request valid
//   data_sram_wen     byte-lane write enables, 4'b0000 = load
//   data_sram_addr    byte address (word index = addr[ADDR_W+1:2])
//   data_sram_wdata   lane-aligned store data
//   data_sram_ready   request can be accepted this cycle
//   data_sram_rdata   load data, held between loads
//   data_sram_rvalid  one-cycle pulse marking valid rdata
//   misalign_err      one-cycle pulse after a rejected store
//   stallreq_from_mem en & ~ready, asks the pipeline to stall
module data_sram_resp #(
  parameter int ADDR_W   = 12,
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_ready,
  output logic [31:0] data_sram_rdata,
  output logic        data_sram_rvalid,
  output logic        misalign_err,
  output logic        stallreq_from_mem
);

  typedef enum logic {IDLE, BUSY} state_e;

  // BUSY counts down from READ_LAT-1; the data is captured when it reaches 1.
  localparam logic [2:0] CNT_INIT = 3'(READ_LAT - 1);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;

  logic [31:0]       mem [0:(1<<ADDR_W)-1];

  logic [ADDR_W-1:0] req_idx;
  logic              accept;
  logic              is_load;
  logic              st_ok;
  logic              mem_we;

  // Upper address bits are deliberately ignored so addresses wrap.
  logic              unused_addr_hi;
  assign unused_addr_hi = ^data_sram_addr[31:ADDR_W+2];

  // Each store pattern is legal only at the one byte offset it fits.
  function automatic logic lane_ok(input logic [3:0] wen, input logic [1:0] lo);
    case (wen)
      4'b0001: lane_ok = (lo == 2'b00);
      4'b0010: lane_ok = (lo == 2'b01);
      4'b0100: lane_ok = (lo == 2'b10);
      4'b1000: lane_ok = (lo == 2'b11);
      4'b0011: lane_ok = (lo == 2'b00);
      4'b1100: lane_ok = (lo == 2'b10);
      4'b1111: lane_ok = (lo == 2'b00);
      default: lane_ok = 1'b0;
    endcase
  endfunction

  assign req_idx           = data_sram_addr[ADDR_W+1:2];
  assign data_sram_ready   = (state_q == IDLE);
  assign stallreq_from_mem = data_sram_en & ~data_sram_ready;
  assign accept            = data_sram_en & data_sram_ready;
  assign is_load           = (data_sram_wen == 4'b0000);
  assign st_ok             = lane_ok(data_sram_wen, data_sram_addr[1:0]);
  assign mem_we            = accept & ~is_load & st_ok;

  assign data_sram_rdata   = rdata_q;
  assign data_sram_rvalid  = rvalid_q;
  assign misalign_err      = err_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_load) begin
            if (READ_LAT == 1) begin
              rdata_d  = mem[req_idx];
              rvalid_d = 1'b1;
            end else begin
              state_d = BUSY;
              cnt_d   = CNT_INIT;
              addr_d  = req_idx;
            end
          end else if (!st_ok) begin
            err_d = 1'b1;
          end
        end
      end
      BUSY: begin
        // No request is accepted in BUSY, so the RAM cannot change under
        // the pending load and the latched address is read directly.
        if (cnt_q > 3'd1) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          rdata_d  = mem[addr_q];
          rvalid_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      rdata_q  <= 32'd0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  // RAM and captured load address carry no reset.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wen[b]) mem[req_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: three instances (READ_LAT 1, 3, 4) share a clock.
// Stimulus pushes expected responses into a scoreboard queue; a monitor pops
// on every rvalid or misalign_err pulse.
module tb_data_sram_resp;
  localparam int N = 3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst    [N];
  logic        en     [N];
  logic [3:0]  wen    [N];
  logic [31:0] addr   [N];
  logic [31:0] wdata  [N];
  logic        ready  [N];
  logic [31:0] rdata  [N];
  logic        rvalid [N];
  logic        merr   [N];
  logic        stall  [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : (g == 1) ? 3 : 4;
    data_sram_resp #(.ADDR_W(12), .READ_LAT(LAT)) u_dut (
      .clk               (clk),
      .rst               (rst[g]),
      .data_sram_en      (en[g]),
      .data_sram_wen     (wen[g]),
      .data_sram_addr    (addr[g]),
      .data_sram_wdata   (wdata[g]),
      .data_sram_ready   (ready[g]),
      .data_sram_rdata   (rdata[g]),
      .data_sram_rvalid  (rvalid[g]),
      .misalign_err      (merr[g]),
      .stallreq_from_mem (stall[g])
    );
  end

  typedef struct {
    int          inst;
    bit          is_err;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    n_cmp++;
    if (act !== ex) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, act, ex);
    end
  endtask

  task automatic take(input int i, input bit e, input logic [31:0] d);
    exp_t x;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_pulse inst%0d err=%0d data=%h: required no pulse", i, e, d);
    end else begin
      x = sb.pop_front();
      if (x.inst != i || x.is_err != e || (!e && d !== x.data)) begin
        n_bad++;
        $display("FAIL response: got inst%0d err=%0d data=%h required inst%0d err=%0d data=%h",
                 i, e, d, x.inst, x.is_err, x.data);
      end
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rvalid[i] === 1'b1) take(i, 1'b0, rdata[i]);
      if (merr[i] === 1'b1) take(i, 1'b1, 32'd0);
    end
  end

  task automatic push(input int i, input bit e, input logic [31:0] d);
    exp_t x;
    x.inst = i; x.is_err = e; x.data = d;
    sb.push_back(x);
  endtask

  task automatic issue(input int i, input logic [3:0] w, input logic [31:0] a,
                       input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    en[i] = 1'b1; wen[i] = w; addr[i] = a; wdata[i] = d;
    while (ready[i] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk($sformatf("ready_timeout_inst%0d", i), {31'd0, ready[i]}, 32'd1);
    if (i == 0) chk("no_stall_lat1", {31'd0, stall[0]}, 32'd0);
  endtask

  task automatic st(input int i, input logic [3:0] w, input logic [31:0] a,
                    input logic [31:0] d, input bit bad);
    if (bad) push(i, 1'b1, 32'd0);
    issue(i, w, a, d);
  endtask

  task automatic ld(input int i, input logic [31:0] a, input logic [31:0] ex);
    push(i, 1'b0, ex);
    issue(i, 4'b0000, a, 32'd0);
  endtask

  task automatic idle(input int i);
    @(negedge clk);
    en[i] = 1'b0; wen[i] = 4'b0000;
  endtask

  initial begin
    exp_t x;
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1; en[i] = 1'b0; wen[i] = 4'b0000; addr[i] = 32'd0; wdata[i] = 32'd0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_rdata%0d", i), rdata[i], 32'd0);
      chk($sformatf("rst_rvalid%0d", i), {31'd0, rvalid[i]}, 32'd0);
      chk($sformatf("rst_merr%0d", i), {31'd0, merr[i]}, 32'd0);
      chk($sformatf("rst_ready%0d", i), {31'd0, ready[i]}, 32'd1);
      chk($sformatf("rst_stall%0d", i), {31'd0, stall[i]}, 32'd0);
      rst[i] = 1'b0;
    end

    // READ_LAT = 1
    st(0, 4'b1111, 32'h10, 32'hDEADBEEF, 0);
    ld(0, 32'h10, 32'hDEADBEEF);
    st(0, 4'b1111, 32'h20, 32'h00000000, 0);
    st(0, 4'b0010, 32'h21, 32'h0000AB00, 0);
    st(0, 4'b1100, 32'h22, 32'h12340000, 0);
    ld(0, 32'h20, 32'h1234AB00);
    st(0, 4'b1111, 32'h30, 32'h11111111, 0);
    st(0, 4'b1111, 32'h32, 32'hFFFFFFFF, 1);
    st(0, 4'b0010, 32'h30, 32'h0000FF00, 1);
    ld(0, 32'h30, 32'h11111111);
    st(0, 4'b0001, 32'h33, 32'h000000EE, 1);
    st(0, 4'b0110, 32'h30, 32'hFFFFFFFF, 1);
    st(0, 4'b1000, 32'h33, 32'hAA000000, 0);
    st(0, 4'b0100, 32'h32, 32'h00BB0000, 0);
    ld(0, 32'h31, 32'hAABB1111);
    st(0, 4'b1111, 32'h4000, 32'hCAFEF00D, 0);
    ld(0, 32'h0000, 32'hCAFEF00D);
    ld(0, 32'h10, 32'hDEADBEEF);
    ld(0, 32'h22, 32'h1234AB00);
    st(0, 4'b0011, 32'h20, 32'h5555C0DE, 0);
    st(0, 4'b0011, 32'h22, 32'h0000FFFF, 1);
    ld(0, 32'h20, 32'h1234C0DE);
    idle(0);
    repeat (3) @(negedge clk);
    chk("rdata_hold_lat1", rdata[0], 32'h1234C0DE);

    // READ_LAT = 3
    st(1, 4'b1111, 32'h40, 32'h55667788, 0);
    st(1, 4'b1111, 32'h44, 32'hA5A5A5A5, 0);
    push(1, 1'b0, 32'h55667788);
    @(negedge clk);
    en[1] = 1'b1; wen[1] = 4'b0000; addr[1] = 32'h40;
    chk("lat3_ready_before", {31'd0, ready[1]}, 32'd1);
    @(negedge clk);
    wen[1] = 4'b1111; addr[1] = 32'h44; wdata[1] = 32'h99999999;
    chk("lat3_ready_c1", {31'd0, ready[1]}, 32'd0);
    chk("lat3_stall_c1", {31'd0, stall[1]}, 32'd1);
    chk("lat3_rvalid_c1", {31'd0, rvalid[1]}, 32'd0);
    @(negedge clk);
    chk("lat3_ready_c2", {31'd0, ready[1]}, 32'd0);
    chk("lat3_stall_c2", {31'd0, stall[1]}, 32'd1);
    chk("lat3_rvalid_c2", {31'd0, rvalid[1]}, 32'd0);
    @(negedge clk);
    chk("lat3_rvalid_c3", {31'd0, rvalid[1]}, 32'd1);
    chk("lat3_rdata_c3", rdata[1], 32'h55667788);
    chk("lat3_ready_c3", {31'd0, ready[1]}, 32'd1);
    chk("lat3_stall_c3", {31'd0, stall[1]}, 32'd0);
    ld(1, 32'h44, 32'h99999999);
    ld(1, 32'h40, 32'h55667788);
    idle(1);
    repeat (6) @(negedge clk);

    // READ_LAT = 4
    st(2, 4'b1111, 32'h50, 32'h0BADF00D, 0);
    ld(2, 32'h50, 32'h0BADF00D);
    idle(2);
    repeat (6) @(negedge clk);
    chk("lat4_rdata", rdata[2], 32'h0BADF00D);
    @(negedge clk);
    en[2] = 1'b1; wen[2] = 4'b0000; addr[2] = 32'h50;
    @(negedge clk);
    en[2] = 1'b0;
    chk("lat4_busy_ready", {31'd0, ready[2]}, 32'd0);
    @(posedge clk);
    #2 rst[2] = 1'b1;
    #1;
    chk("midrst_ready", {31'd0, ready[2]}, 32'd1);
    chk("midrst_rdata", rdata[2], 32'd0);
    chk("midrst_rvalid", {31'd0, rvalid[2]}, 32'd0);
    chk("midrst_stall", {31'd0, stall[2]}, 32'd0);
    @(negedge clk);
    rst[2] = 1'b0;
    repeat (6) @(negedge clk);
    chk("midrst_rdata_after", rdata[2], 32'd0);
    chk("midrst_ready_after", {31'd0, ready[2]}, 32'd1);

    repeat (2) @(negedge clk);
    while (sb.size() > 0) begin
      x = sb.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_response: got none required inst%0d err=%0d data=%h",
               x.inst, x.is_err, x.data);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_sram_resp.md
# data_sram_resp

Data-memory responder for the five-stage MIPS core. It sits on the far end of the `data_sram_*` request interface that EX drives: it stores words in an internal byte-lane RAM, posts byte, half and word stores, and returns load data after a fixed, configurable latency. It also raises a stall request while a load is in flight. It checks that every write-enable pattern agrees with the address low bits and rejects any store that does not.

## Interface
- `ADDR_W`, default 12: word-address width; RAM depth is 2^ADDR_W words.
- `READ_LAT`, default 1: load latency in cycles; legal range 1..4.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `data_sram_en`  in  1  request valid.
- `data_sram_wen`  in  4  byte-lane write enables; `4'b0000` means a load.
- `data_sram_addr`  in  32  byte address.
- `data_sram_wdata`  in  32  store data, already lane-aligned by EX.
- `data_sram_ready`  out  1  responder can accept a request this cycle.
- `data_sram_rdata`  out  32  load data; holds its value between loads.
- `data_sram_rvalid`  out  1  one-cycle pulse marking valid `data_sram_rdata`.
- `misalign_err`  out  1  one-cycle pulse: store rejected.
- `stallreq_from_mem`  out  1  equals `data_sram_en & ~data_sram_ready`.

## Operation
- **Accept rule:** a request is accepted at a rising edge when `data_sram_en` and `data_sram_ready` are both 1.
- **Word index:** `data_sram_addr[ADDR_W+1:2]`. Upper address bits are ignored, so addresses wrap modulo the RAM size. `addr[1:0]` is used only for the lane check.
- **Legal store patterns:**
  - `0001` with `addr[1:0]`=00, `0010` with 01, `0100` with 10, `1000` with 11.
  - `0011` with 00; `1100` with 10.
  - `1111` with 00.
- **Illegal store:** any other nonzero `wen`, or a legal pattern with a mismatched `addr[1:0]`, is rejected. No lane is written, and `misalign_err` pulses in the cycle after the accept edge.
- **Legal store:** only the enabled byte lanes of the word are written, at the accept edge. Stores are posted: no response, and `data_sram_ready` stays 1.
- **Load:** always reads a full word; `addr[1:0]` is ignored and never causes an error.
- **FSM states:**
  - IDLE: ready=1.
  - BUSY: ready=0, down-counter `cnt` active; entered only when `READ_LAT` > 1.
  - Transitions:
    - Load accepted in IDLE: if `READ_LAT`=1, stay in IDLE and register the data; otherwise go to BUSY with `cnt`=`READ_LAT`-1.
    - BUSY with `cnt`>1: decrement `cnt`.
    - BUSY with `cnt`=1: register the RAM word into `data_sram_rdata`, pulse `data_sram_rvalid`, return to IDLE.
- **Captured address:** the load address is latched at accept. Address changes while in BUSY have no effect.
- **RAM contents:** not reset; initial contents are undefined.

## Timing
- **Reset values:** `data_sram_rdata`=0, `data_sram_rvalid`=0, `misalign_err`=0, state=IDLE. Therefore `data_sram_ready`=1 and `stallreq_from_mem`=0.
- **Load latency:** a load accepted at edge k has `rvalid`=1 and valid data in the cycle after edge k+`READ_LAT`-1. `data_sram_ready` is 0 for the `READ_LAT`-1 cycles before that.
- **`READ_LAT`=1:** back-to-back loads and stores are accepted every cycle, with no stall.
- **Read-after-write:** a store at edge k followed by a load of the same word at edge k+1 returns the stored data. There is no same-edge read/write conflict, since only one request is accepted per edge.
- **Requests while busy:** a request held during BUSY is not accepted. It is accepted on the first edge where `data_sram_ready`=1, i.e. the edge that ends the `rvalid` cycle.
- **Reset mid-load:** the load is aborted, no `rvalid` pulse follows, and the outputs return to their reset values immediately.
- **Output timing:** `rvalid` and `misalign_err` are registered outputs. `data_sram_ready` and `stallreq_from_mem` are combinational from state (and `data_sram_en`).

## Test plan
- **Word store and load** (`READ_LAT`=1): store `wen=1111`, addr 0x10, data 0xDEADBEEF; next cycle load addr 0x10 -> next cycle `rvalid`=1, `rdata`=0xDEADBEEF, no stall at any point.
- **Byte and half stores:**
  - Preload word 0x20 with 0x00000000.
  - Store `0010` at 0x21 with wdata 0x0000AB00.
  - Store `1100` at 0x22 with 0x12340000.
  - Load 0x20 -> `rdata`=0x1234AB00.
- **Misaligned stores:**
  - Preload 0x30 with 0x11111111.
  - Store `1111` at 0x32 -> `misalign_err` pulses 1 cycle.
  - Store `0010` at 0x30 -> another `misalign_err` pulse.
  - Load 0x30 -> 0x11111111, unchanged.
- **Latency 3:** with `READ_LAT`=3, load accepted at edge 0 -> `ready`=0 and `stallreq_from_mem`=1 for 2 cycles while `en` is held. A store presented during that time is not written until `ready` returns. `rvalid` appears after edge 2.
- **Wrap-around** (`ADDR_W`=12): store 0xCAFEF00D at 0x4000; load 0x0000 -> 0xCAFEF00D.
- **Reset mid-load** (`READ_LAT`=4): assert `rst` asynchronously one cycle after accepting a load -> `ready`=1 immediately, `rvalid` never pulses, `rdata`=0.
